// File: rtl/div_cfg_sched_pkg.sv
// rtl/div_cfg_sched_pkg.sv - shared state encoding and constants for the divider config scheduler
package div_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_ENABLE = 2'd3
  } state_e;

  // Smallest ratio the divider can produce.
  localparam int DIV_MIN = 2;

endpackage

// File: rtl/div_cfg_sched_if.sv
// rtl/div_cfg_sched_if.sv - request/grant and divider-control bundle of the config scheduler
interface div_cfg_sched_if #(
  parameter int N_REQ = 4,
  parameter int DIV_W = 16
);

  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*DIV_W-1:0] i_div_val;
  logic [N_REQ-1:0]       o_gnt;
  logic                   o_err;
  logic [DIV_W-1:0]       o_div_num;
  logic                   o_sw;
  logic                   o_busy;

  // Requester / control-source side.
  modport master (
    output i_req, i_div_val,
    input  o_gnt, o_err, o_div_num, o_sw, o_busy
  );

  // Scheduler side.
  modport slave (
    input  i_req, i_div_val,
    output o_gnt, o_err, o_div_num, o_sw, o_busy
  );

endinterface

// File: rtl/div_cfg_sched_rr_arbiter.sv
// rtl/div_cfg_sched_rr_arbiter.sv - combinational round-robin pick starting at a priority pointer
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         win,
  output logic                     any
);

  localparam int PW = $clog2(N_REQ);

  // First asserted request at or above ptr, wrapping past the top.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[PW'((int'(ptr) + i) % N_REQ)]) begin
        win[PW'((int'(ptr) + i) % N_REQ)] = 1'b1;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_cfg_sched.sv
// rtl/div_cfg_sched.sv - arbitrates ratio requests and sequences glitch-free divider reloads
module div_cfg_sched
  import div_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DIV_W      = 16,
  parameter int SETTLE_CYC = 4,
  parameter int DEF_DIV    = 2
) (
  input logic            clk,
  input logic            rstn,
  div_cfg_sched_if.slave bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(SETTLE_CYC + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]   pend_q, pend_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               err_q, err_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sw_q, sw_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   win;
  logic               any;
  logic [PW-1:0]      win_idx;
  logic [DIV_W-1:0]   win_val;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (bus.i_req),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  // Turn the one-hot winner into an index and pick out its requested ratio.
  always_comb begin
    win_idx = '0;
    win_val = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_idx = PW'(i);
        win_val = bus.i_div_val[i*DIV_W +: DIV_W];
      end
    end
  end

  // Sequencer: grant, gate off, settle, load ratio, re-enable.
  // The grant edge already counts as the first settle cycle, so a granted
  // change seeds the counter at 1; the boot drain has no grant edge and
  // starts from 0, which makes it one cycle longer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    err_d   = 1'b0;
    div_d   = div_q;
    sw_d    = sw_q;
    busy_d  = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        sw_d   = 1'b1;
        busy_d = 1'b0;
        if (any) begin
          gnt_d = win;
          ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          if (win_val < DIV_W'(DIV_MIN)) begin
            err_d = 1'b1;
          end else if (win_val != div_q) begin
            pend_d  = win_val;
            cnt_d   = CW'(1);
            state_d = ST_DRAIN;
            sw_d    = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        sw_d   = 1'b0;
        busy_d = 1'b1;
        if (cnt_q >= CW'(SETTLE_CYC - 1)) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        div_d   = pend_q;
        state_d = ST_ENABLE;
      end
      ST_ENABLE: begin
        sw_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops straight into the boot drain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_DRAIN;
      cnt_q   <= '0;
      pend_q  <= DIV_W'(DEF_DIV);
      ptr_q   <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      div_q   <= DIV_W'(DEF_DIV);
      sw_q    <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      div_q   <= div_d;
      sw_q    <= sw_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_gnt     = gnt_q;
  assign bus.o_err     = err_q;
  assign bus.o_div_num = div_q;
  assign bus.o_sw      = sw_q;
  assign bus.o_busy    = busy_q;

endmodule
